// File: rtl/riscv_mem_pkg.sv
// Shared data-memory parameters and types for the load/store path.
package riscv_mem_pkg;

  localparam int RISC_V_DATA_WIDTH         = 32;
  localparam int DATA_MEMORY_ADDRESS_WIDTH = 10;
  localparam int DATA_MEMORY_ROM_DEPTH     = 256;
  localparam int DATA_MEMORY_RAM_DEPTH     = (1 << DATA_MEMORY_ADDRESS_WIDTH) - DATA_MEMORY_ROM_DEPTH;

  typedef enum logic [2:0] {
    LSU_LB  = 3'b000,
    LSU_LH  = 3'b001,
    LSU_LW  = 3'b010,
    LSU_LBU = 3'b100,
    LSU_LHU = 3'b101
  } lsu_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte/halfword lane steering: extends load data and merges sub-word store data
// into a word read from memory (little-endian).
module lsu_byte_lane
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [15:0] store_data_i,
  output logic [31:0] load_val_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word_i[{lane_i, 3'b000} +: 8];
    half_sel   = word_i[{lane_i[1], 4'b0000} +: 16];
    load_val_o = word_i;
    merge_o    = word_i;
    case (funct3_i)
      LSU_LB:  load_val_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: load_val_o = {24'd0, byte_sel};
      LSU_LH:  load_val_o = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: load_val_o = {16'd0, half_sel};
      default: load_val_o = word_i;
    endcase
    // Only SB (x00) and SH (x01) ever reach the merge path.
    case (funct3_i[1:0])
      2'b00:   merge_o[{lane_i, 3'b000} +: 8]     = store_data_i[7:0];
      2'b01:   merge_o[{lane_i[1], 4'b0000} +: 16] = store_data_i;
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, sub-word stores done as
// read-modify-write, single-cycle response pulse carrying data or a fault.
module load_store_unit
  import riscv_mem_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_is_store,
  input  logic [2:0]                           req_funct3,
  input  logic [31:0]                          req_addr,
  input  logic [31:0]                          req_wdata,
  output logic                                 resp_valid,
  output logic [31:0]                          resp_rdata,
  output logic                                 resp_fault,
  output logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] mem_address,
  output logic [31:0]                          mem_w_data,
  input  logic [31:0]                          mem_r_data,
  output logic                                 mem_ctrl_w,
  output logic                                 mem_ctrl_r
);

  localparam int AW = DATA_MEMORY_ADDRESS_WIDTH;
  localparam logic [AW-1:0] ROM_LAST = AW'(DATA_MEMORY_ROM_DEPTH);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and the requester holds req_valid otherwise.
  lsu_state_t    state_q, state_d;
  logic [2:0]    funct3_q;
  logic          is_store_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] waddr_q;
  logic [31:0]   wdata_q;
  logic          fault_q;
  logic [31:0]   rdata_q;
  logic [31:0]   merge_q;

  logic          accept;
  logic          addr_hi_bad;
  logic          misaligned;
  logic          funct3_bad;
  logic          rom_store;
  logic          req_fault;
  logic          is_sw;
  logic [31:0]   load_val;
  logic [31:0]   merge_val;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    addr_hi_bad = |req_addr[31:AW+2];
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    if (req_is_store)
      funct3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      funct3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // The memory rejects writes at word ROM_DEPTH as well as below it.
    rom_store = req_is_store && (req_addr[AW+1:2] <= ROM_LAST);
    req_fault = addr_hi_bad || misaligned || funct3_bad || rom_store;
  end

  assign is_sw = is_store_q && (funct3_q == 3'b010);

  lsu_byte_lane u_byte_lane (
    .word_i       (mem_r_data),
    .lane_i       (lane_q),
    .funct3_i     (funct3_q),
    .store_data_i (wdata_q[15:0]),
    .load_val_o   (load_val),
    .merge_o      (merge_val)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_fault ? DONE : ACCESS;
      ACCESS:  state_d = (is_store_q && !is_sw) ? WRITE : DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      funct3_q   <= 3'd0;
      is_store_q <= 1'b0;
      lane_q     <= 2'd0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      fault_q    <= 1'b0;
      rdata_q    <= 32'd0;
      merge_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q   <= req_funct3;
        is_store_q <= req_is_store;
        lane_q     <= req_addr[1:0];
        waddr_q    <= req_addr[AW+1:2];
        wdata_q    <= req_wdata;
        fault_q    <= req_fault;
        rdata_q    <= 32'd0;
      end
      if (state_q == ACCESS) begin
        if (!is_store_q) rdata_q <= load_val;
        merge_q <= merge_val;
      end
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_fault  = (state_q == DONE) && fault_q;
  assign resp_rdata  = (state_q == DONE) ? rdata_q : 32'd0;
  assign mem_address = waddr_q;
  assign mem_ctrl_r  = (state_q == ACCESS) && !is_sw;
  assign mem_ctrl_w  = ((state_q == ACCESS) && is_sw) || (state_q == WRITE);
  assign mem_w_data  = (state_q == WRITE) ? merge_q :
                       ((state_q == ACCESS) && is_sw) ? wdata_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide data memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [9:0]  mem_address;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  logic        mem_ctrl_w;
  logic        mem_ctrl_r;

  int total = 0;
  int passed = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  assign mem_r_data = mem[mem_address];
  always @(posedge clk) if (mem_ctrl_w) mem[mem_address] <= mem_w_data;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_address  (mem_address),
    .mem_w_data   (mem_w_data),
    .mem_r_data   (mem_r_data),
    .mem_ctrl_w   (mem_ctrl_w),
    .mem_ctrl_r   (mem_ctrl_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {ctrl_r, ctrl_w, resp_valid, resp_fault}
  function automatic logic [31:0] ctl();
    return {28'd0, mem_ctrl_r, mem_ctrl_w, resp_valid, resp_fault};
  endfunction

  // Returns at the falling edge of cycle T+1 (T = accept edge).
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    check("ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    issue(1'b0, f3, a, 32'd0);
    check({tag, "_t1_ctl"}, ctl(), 32'h8);
    check({tag, "_t1_addr"}, {22'd0, mem_address}, {22'd0, a[11:2]});
    @(negedge clk);
    check({tag, "_t2_ctl"}, ctl(), 32'h2);
    check({tag, "_t2_rdata"}, resp_rdata, exp);
  endtask

  task automatic do_fault(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
    issue(st, f3, a, 32'hDEADBEEF);
    check({tag, "_t1_ctl"}, ctl(), 32'h3);
    check({tag, "_t1_rdata"}, resp_rdata, 32'd0);
    @(negedge clk);
    check({tag, "_t2_ctl"}, ctl(), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[10'h120] = 32'h8899AABB;
    mem[10'h121] = 32'hCAFEF00D;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'd0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_ctl", ctl(), 32'h0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addr", {22'd0, mem_address}, 32'd0);
    check("rst_wdata", mem_w_data, 32'd0);
    rst = 1'b0;

    do_load("lb", 3'b000, 32'h481, 32'hFFFFFFAA);
    do_load("lbu", 3'b100, 32'h481, 32'h000000AA);
    do_load("lhu", 3'b101, 32'h482, 32'h00008899);
    do_load("lh", 3'b001, 32'h480, 32'hFFFFAABB);

    issue(1'b1, 3'b000, 32'h483, 32'h0000005C);
    check("sb_t1_ctl", ctl(), 32'h8);
    @(negedge clk);
    check("sb_t2_ctl", ctl(), 32'h4);
    check("sb_t2_wdata", mem_w_data, 32'h5C99AABB);
    @(negedge clk);
    check("sb_t3_ctl", ctl(), 32'h2);
    check("sb_t3_rdata", resp_rdata, 32'd0);
    do_load("lw_after_sb", 3'b010, 32'h480, 32'h5C99AABB);

    issue(1'b1, 3'b001, 32'h482, 32'h0000BEEF);
    check("sh_t1_ctl", ctl(), 32'h8);
    @(negedge clk);
    check("sh_t2_wdata", mem_w_data, 32'hBEEFAABB);
    @(negedge clk);
    check("sh_t3_ctl", ctl(), 32'h2);

    issue(1'b1, 3'b010, 32'h480, 32'h12345678);
    check("sw_t1_ctl", ctl(), 32'h4);
    check("sw_t1_wdata", mem_w_data, 32'h12345678);
    @(negedge clk);
    check("sw_t2_ctl", ctl(), 32'h2);
    do_load("lw_after_sw", 3'b010, 32'h480, 32'h12345678);

    do_fault("f_lh_odd", 1'b0, 3'b001, 32'h481);
    do_fault("f_sw_rom", 1'b1, 3'b010, 32'h3FC);
    do_fault("f_sw_w256", 1'b1, 3'b010, 32'h400);
    do_fault("f_lw_range", 1'b0, 3'b010, 32'h10000);
    do_fault("f_ld_f3", 1'b0, 3'b011, 32'h480);
    do_fault("f_st_f3", 1'b1, 3'b100, 32'h480);

    // Reset while the merge write of an SB is on the bus.
    issue(1'b1, 3'b000, 32'h481, 32'h00000011);
    check("rw_t1_ctl", ctl(), 32'h8);
    @(negedge clk);
    check("rw_t2_ctl", ctl(), 32'h4);
    check("rw_t2_wdata", mem_w_data, 32'h12341178);
    rst = 1'b1;
    @(negedge clk);
    check("rw_rst_ctl", ctl(), 32'h0);
    check("rw_rst_ready", {31'd0, req_ready}, 32'd1);
    check("rw_rst_addr", {22'd0, mem_address}, 32'd0);
    check("rw_rst_wdata", mem_w_data, 32'd0);
    check("rw_rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rw_after_ctl", ctl(), 32'h0);
    do_load("lw_after_rst", 3'b010, 32'h484, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port. Accepts one load or store per handshake from the execute stage and converts byte addresses to word addresses. Drives the data memory's word-wide read/write controls, building byte and halfword stores as read-modify-write. Returns sign- or zero-extended load data, or a fault, as a one-cycle response pulse.

## Interface
- RISC_V_DATA_WIDTH, 32, data word width; fixed at 32 for this block
- DATA_MEMORY_ADDRESS_WIDTH, 10, word-address width of the data memory
- DATA_MEMORY_ROM_DEPTH, 256, words of read-only region at word address 0
- Reset is synchronous and active-high; one clock.
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  valid with resp_valid; misaligned, illegal funct3, out of range, or ROM store
- mem_address  out  DATA_MEMORY_ADDRESS_WIDTH  word address to memory
- mem_w_data  out  32  write data to memory
- mem_r_data  in  32  combinational read data from memory
- mem_ctrl_w  out  1  memory write enable; write occurs at the next clock edge
- mem_ctrl_r  out  1  memory read enable

## Operation
- FSM states: IDLE, ACCESS, WRITE, DONE. req_ready = 1 only in IDLE.
- IDLE, on accept: register funct3, is_store, byte lane = req_addr[1:0], word address = req_addr[DATA_MEMORY_ADDRESS_WIDTH+1:2], wdata. Then check:
  - Fault if any req_addr bit above DATA_MEMORY_ADDRESS_WIDTH+1 is set.
  - Fault if halfword access has addr[0] = 1, or word access has addr[1:0] != 0.
  - Fault if funct3 is not in the list above for the access type.
  - Fault if a store has word address <= DATA_MEMORY_ROM_DEPTH. The memory does not accept writes at ROM_DEPTH itself.
  - On fault go to DONE; otherwise go to ACCESS.
- ACCESS:
  - Load: mem_ctrl_r = 1. Select byte (lane) or half (addr[1]) from mem_r_data, little-endian. Sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW. Register into resp_rdata; go to DONE.
  - SW: mem_ctrl_w = 1, mem_w_data = wdata; go to DONE.
  - SB/SH: mem_ctrl_r = 1. Register merge = mem_r_data with byte [8*lane+7:8*lane] (SB) or half [16*addr[1]+15:16*addr[1]] (SH) replaced by wdata[7:0]/[15:0]. Go to WRITE.
- WRITE: mem_ctrl_w = 1, mem_w_data = merge; go to DONE.
- DONE: resp_valid = 1, resp_fault per the checks; go to IDLE.
- mem_ctrl_r and mem_ctrl_w are never both 1. Both are 0 in IDLE, DONE, and on the fault path.
- mem_address holds the registered word address from accept until the next accept.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_fault 0, resp_rdata 0, mem_address 0, mem_w_data 0, mem_ctrl_w 0, mem_ctrl_r 0.
- Accept at edge T. Latencies:
  - Load / SW: ACCESS in cycle T+1, resp_valid in T+2.
  - SB/SH: read in T+1, write in T+2, resp_valid in T+3.
  - Fault: resp_valid in T+1.
- Minimum spacing between accepts: 3 cycles (load/SW), 4 (SB/SH), 2 (fault).
- req_valid while not ready is ignored; the requester holds it.
- rst asserted in any state: next cycle is IDLE with reset values. The pending request is dropped with no response. A memory write already clocked is not undone. The merge read is discarded.
- Outputs are registered or decoded from state only; no combinational path from req_* to mem_* or resp_*.

## Structure
- Shared package riscv_mem_pkg:
  - RISC_V_DATA_WIDTH, DATA_MEMORY_ADDRESS_WIDTH, DATA_MEMORY_ROM_DEPTH, DATA_MEMORY_RAM_DEPTH
  - lsu_funct3_t enum (LB, LH, LW, LBU, LHU)
  - lsu_state_t enum (IDLE, ACCESS, WRITE, DONE)
- One sub-module, lsu_byte_lane (combinational). Given word, lane, funct3 and store data, it produces:
  - the extended load value
  - the merged store word

## Test plan
- Setup: preload RAM word 0x120 = 0x8899AABB.
- LB at byte address 0x481 (word 0x120, lane 1) -> resp_valid at T+2, resp_rdata 0xFFFFFFAA, no fault. LBU -> 0x000000AA. LHU at 0x482 -> 0x00008899.
- SB 0x5C to 0x483 -> read in T+1, write 0x5C99AABB in T+2, resp at T+3. A following LW at 0x480 returns 0x5C99AABB.
- SW at 0x480 with data 0x12345678 -> mem_ctrl_w only in T+1, resp at T+2. LW returns 0x12345678.
- Fault cases, each -> resp_valid at T+1, resp_fault 1, no mem_ctrl_r/w ever asserted:
  - LH at 0x481
  - SW at 0x3FC (ROM region)
  - SW at word 256 (byte 0x400)
  - LW at 0x10000
  - load funct3 011
- rst asserted in WRITE state of an SB -> no resp_valid, all outputs at reset values next cycle. The next LW is accepted normally.
